// File: rtl/dcache_responder_pkg.sv
// Shared types and geometry for the LSQ-facing direct-mapped write-back data cache.
package dcache_responder_pkg;

  localparam int unsigned ADDR_WIDTH   = 16;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned INDEX_WIDTH  = 4;
  localparam int unsigned OFFSET_WIDTH = 2;
  localparam int unsigned TAG_ID_WIDTH = 3;
  localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned LINE_WORDS   = 1 << OFFSET_WIDTH;
  localparam int unsigned NUM_LINES    = 1 << INDEX_WIDTH;
  localparam int unsigned SLOT_WIDTH   = INDEX_WIDTH + OFFSET_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]   addr_t;
  typedef logic [DATA_WIDTH-1:0]   data_t;
  typedef logic [TAG_WIDTH-1:0]    tag_t;
  typedef logic [INDEX_WIDTH-1:0]  idx_t;
  typedef logic [OFFSET_WIDTH-1:0] off_t;
  typedef logic [SLOT_WIDTH-1:0]   slot_t;
  typedef logic [TAG_ID_WIDTH-1:0] id_t;

  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_action_t;

  typedef enum logic [1:0] {IDLE, WB, FILL_REQ, FILL_WAIT} dcache_state_t;

  typedef struct packed {
    mem_action_t act;
    addr_t       addr;
    data_t       wdata;
  } mem_req_t;

  function automatic addr_t line_addr(input tag_t tag, input idx_t idx, input off_t off);
    return {tag, idx, off};
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// LSQ request/response and memory-port signals between the cache and its environment.
interface dcache_responder_if;
  import dcache_responder_pkg::*;

  logic  req_valid;
  logic  req_write;
  addr_t req_addr;
  data_t req_wdata;
  id_t   req_id;
  logic  dc_miss;
  logic  resp_valid;
  logic  resp_write;
  data_t resp_rdata;
  id_t   resp_id;
  logic  mem_req_valid;
  logic  mem_req_ready;
  logic  mem_req_write;
  addr_t mem_req_addr;
  data_t mem_req_wdata;
  logic  mem_resp_valid;
  data_t mem_resp_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_id,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output dc_miss, resp_valid, resp_write, resp_rdata, resp_id,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_id,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  dc_miss, resp_valid, resp_write, resp_rdata, resp_id,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );

endinterface

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty and data arrays: combinational reads, one data write port per cycle.
module dcache_line_store
  import dcache_responder_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  idx_t  i_meta_idx,
  output tag_t  o_tag,
  output logic  o_valid,
  output logic  o_dirty,
  input  slot_t i_rd_slot_a,
  output data_t o_rd_data_a,
  input  slot_t i_rd_slot_b,
  output data_t o_rd_data_b,
  input  logic  i_wr_en,
  input  slot_t i_wr_slot,
  input  data_t i_wr_data,
  input  logic  i_set_dirty,
  input  logic  i_line_done,
  input  idx_t  i_line_idx,
  input  tag_t  i_line_tag
);

  tag_t                 r_tag  [NUM_LINES];
  data_t                r_data [NUM_LINES*LINE_WORDS];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  idx_t                 w_wr_idx;

  assign w_wr_idx    = i_wr_slot[SLOT_WIDTH-1 -: INDEX_WIDTH];
  assign o_tag       = r_tag[i_meta_idx];
  assign o_valid     = r_valid[i_meta_idx];
  assign o_dirty     = r_dirty[i_meta_idx];
  assign o_rd_data_a = r_data[i_rd_slot_a];
  assign o_rd_data_b = r_data[i_rd_slot_b];

  // Storage arrays carry no reset; only the line state bits do.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_data[i_wr_slot] <= i_wr_data;
    if (i_line_done) r_tag[i_line_idx] <= i_line_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_done) begin
      r_valid[i_line_idx] <= 1'b1;
      r_dirty[i_line_idx] <= 1'b0;
    end else if (i_wr_en && i_set_dirty) begin
      r_dirty[w_wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache servicing one LSQ word access per cycle.
module dcache_responder
  import dcache_responder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  dcache_responder_if.slave bus
);

  dcache_state_t r_state;
  off_t          r_word_cnt;
  idx_t          r_miss_idx;
  tag_t          r_miss_tag;
  tag_t          r_victim_tag;
  logic          r_resp_valid;
  logic          r_resp_write;
  data_t         r_resp_rdata;
  id_t           r_resp_id;
  logic          r_mem_req_valid;
  mem_req_t      r_mem_req;

  tag_t  w_req_tag;
  idx_t  w_req_idx;
  off_t  w_req_off;
  tag_t  w_tag;
  logic  w_valid;
  logic  w_dirty;
  logic  w_hit;
  logic  w_idle;
  logic  w_wr_hit;
  logic  w_fill_beat;
  logic  w_last;
  off_t  w_cnt_next;
  idx_t  w_wb_idx;
  off_t  w_wb_off;
  data_t w_rd_word;
  data_t w_wb_word;

  assign w_req_tag   = bus.req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_req_idx   = bus.req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_req_off   = bus.req_addr[OFFSET_WIDTH-1:0];
  assign w_idle      = (r_state == IDLE);
  assign w_hit       = w_valid && (w_tag == w_req_tag);
  assign w_wr_hit    = w_idle && bus.req_valid && w_hit && bus.req_write;
  assign w_fill_beat = (r_state == FILL_WAIT) && bus.mem_resp_valid;
  assign w_last      = (r_word_cnt == off_t'(LINE_WORDS - 1));
  assign w_cnt_next  = r_word_cnt + off_t'(1);

  // Port B prefetches the writeback word that goes out after the current handshake.
  assign w_wb_idx = w_idle ? w_req_idx : r_miss_idx;
  assign w_wb_off = w_idle ? off_t'(0) : w_cnt_next;

  dcache_line_store u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_meta_idx  (w_req_idx),
    .o_tag       (w_tag),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .i_rd_slot_a ({w_req_idx, w_req_off}),
    .o_rd_data_a (w_rd_word),
    .i_rd_slot_b ({w_wb_idx, w_wb_off}),
    .o_rd_data_b (w_wb_word),
    .i_wr_en     (w_wr_hit || w_fill_beat),
    .i_wr_slot   (w_fill_beat ? {r_miss_idx, r_word_cnt} : {w_req_idx, w_req_off}),
    .i_wr_data   (w_fill_beat ? bus.mem_resp_rdata : bus.req_wdata),
    .i_set_dirty (w_wr_hit),
    .i_line_done (w_fill_beat && w_last),
    .i_line_idx  (r_miss_idx),
    .i_line_tag  (r_miss_tag)
  );

  assign bus.dc_miss       = !w_idle || (bus.req_valid && !w_hit);
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_write    = r_resp_write;
  assign bus.resp_rdata    = r_resp_rdata;
  assign bus.resp_id       = r_resp_id;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_req_write = (r_mem_req.act == MEM_WRITE);
  assign bus.mem_req_addr  = r_mem_req.addr;
  assign bus.mem_req_wdata = r_mem_req.wdata;

  // Lookup, writeback and refill sequencing; responses only ever leave from IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_word_cnt      <= '0;
      r_miss_idx      <= '0;
      r_miss_tag      <= '0;
      r_victim_tag    <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_write    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_id       <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req       <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid && w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_write <= bus.req_write;
            r_resp_rdata <= bus.req_write ? '0 : w_rd_word;
            r_resp_id    <= bus.req_id;
          end else if (bus.req_valid) begin
            r_miss_idx      <= w_req_idx;
            r_miss_tag      <= w_req_tag;
            r_victim_tag    <= w_tag;
            r_word_cnt      <= '0;
            r_mem_req_valid <= 1'b1;
            if (w_valid && w_dirty) begin
              r_state   <= WB;
              r_mem_req <= '{act: MEM_WRITE, addr: line_addr(w_tag, w_req_idx, off_t'(0)),
                             wdata: w_wb_word};
            end else begin
              r_state   <= FILL_REQ;
              r_mem_req <= '{act: MEM_READ, addr: line_addr(w_req_tag, w_req_idx, off_t'(0)),
                             wdata: '0};
            end
          end
        end
        WB: begin
          if (bus.mem_req_ready) begin
            r_word_cnt <= w_cnt_next;
            if (w_last) begin
              r_state   <= FILL_REQ;
              r_mem_req <= '{act: MEM_READ, addr: line_addr(r_miss_tag, r_miss_idx, off_t'(0)),
                             wdata: '0};
            end else begin
              r_mem_req <= '{act: MEM_WRITE, addr: line_addr(r_victim_tag, r_miss_idx, w_cnt_next),
                             wdata: w_wb_word};
            end
          end
        end
        FILL_REQ: begin
          if (bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (bus.mem_resp_valid) begin
            r_word_cnt <= w_cnt_next;
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_state         <= FILL_REQ;
              r_mem_req_valid <= 1'b1;
              r_mem_req.addr  <= line_addr(r_miss_tag, r_miss_idx, w_cnt_next);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench: directed LSQ traffic against a behavioural memory with expected-response queues.
module tb_dcache_responder;
  import dcache_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_responder_if bus();

  dcache_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {logic wr; data_t rdata; id_t id;} exp_resp_t;
  typedef struct packed {logic wr; addr_t addr; data_t wdata;} exp_mem_t;

  exp_resp_t resp_q[$];
  exp_mem_t  mem_q[$];
  data_t     mem [0:65535];

  int    n_checks = 0;
  int    n_fail = 0;
  int    stall_left = 0;
  bit    stall_armed = 1'b0;
  addr_t cap_addr;
  data_t cap_wdata;
  bit    stray = 1'b0;
  bit    pend = 1'b0;
  addr_t pend_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_mem(input logic wr, input addr_t a, input data_t d);
    exp_mem_t e;
    e.wr = wr; e.addr = a; e.wdata = d;
    mem_q.push_back(e);
  endtask

  task automatic exp_fill(input addr_t base);
    for (int i = 0; i < 4; i++) exp_mem(1'b0, base + addr_t'(i), '0);
  endtask

  // Drive one request at a negedge, hold it until accepted, return at the negedge after acceptance.
  task automatic issue(input logic wr, input addr_t a, input data_t d, input id_t id,
                       input data_t exp_rd, input logic exp_miss);
    int cyc = 0;
    exp_resp_t e;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
    bus.req_wdata = d;    bus.req_id = id;
    e.wr = wr; e.rdata = wr ? 32'h0 : exp_rd; e.id = id;
    resp_q.push_back(e);
    #1;
    check("dc_miss_on_issue", 32'(bus.dc_miss), 32'(exp_miss));
    while (bus.dc_miss && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    if (bus.dc_miss) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: addr 0x%04h still dc_miss=1 after %0d cycles, required 0", a, cyc);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Behavioural memory: optional backpressure, request checking, one-cycle refill return.
  initial begin
    exp_mem_t e;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (pend) begin
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = mem[pend_addr]; pend = 1'b0;
      end else if (stray) begin
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h5555_5555; stray = 1'b0;
      end
      if (stall_left > 0 && bus.mem_req_valid) begin
        bus.mem_req_ready = 1'b0;
        if (!stall_armed) begin
          cap_addr = bus.mem_req_addr; cap_wdata = bus.mem_req_wdata; stall_armed = 1'b1;
        end else begin
          check("stall_addr_stable", 32'(bus.mem_req_addr), 32'(cap_addr));
          check("stall_wdata_stable", bus.mem_req_wdata, cap_wdata);
        end
        check("stall_dc_miss", 32'(bus.dc_miss), 32'd1);
        stall_left--;
      end else begin
        bus.mem_req_ready = 1'b1;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (mem_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mem_unexpected: got mem request addr 0x%04h write=%0b, required none",
                   bus.mem_req_addr, bus.mem_req_write);
        end else begin
          e = mem_q.pop_front();
          check("mem_req_write", 32'(bus.mem_req_write), 32'(e.wr));
          check("mem_req_addr", 32'(bus.mem_req_addr), 32'(e.addr));
          if (e.wr) check("mem_req_wdata", bus.mem_req_wdata, e.wdata);
        end
        if (bus.mem_req_write) mem[bus.mem_req_addr] = bus.mem_req_wdata;
        else begin pend = 1'b1; pend_addr = bus.mem_req_addr; end
      end
    end
  end

  // Response monitor: every resp_valid pulse must match the oldest expected response.
  initial begin
    exp_resp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL resp_unexpected: got resp_valid=1 id=%0d rdata=0x%08h, required no response",
                   bus.resp_id, bus.resp_rdata);
        end else begin
          e = resp_q.pop_front();
          check("resp_write", 32'(bus.resp_write), 32'(e.wr));
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_id", 32'(bus.resp_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_id = '0;
    for (int i = 0; i < 4; i++) begin
      mem[16'h0010 + 16'(i)] = 32'hA0 + 32'(i);
      mem[16'h0410 + 16'(i)] = 32'hB0 + 32'(i);
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_write", 32'(bus.resp_write), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_mem_req_write", 32'(bus.mem_req_write), 32'd0);
    check("rst_mem_req_addr", 32'(bus.mem_req_addr), 32'd0);
    check("rst_mem_req_wdata", bus.mem_req_wdata, 32'd0);
    check("rst_dc_miss", 32'(bus.dc_miss), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read, then write hit followed back-to-back by a read of the same word.
    exp_fill(16'h0010);
    issue(1'b0, 16'h0010, '0, 3'd1, 32'hA0, 1'b1);
    issue(1'b1, 16'h0011, 32'hDEAD_BEEF, 3'd2, '0, 1'b0);
    issue(1'b0, 16'h0011, '0, 3'd3, 32'hDEAD_BEEF, 1'b0);
    idle(1);

    // Dirty eviction of index 4 by tag 0x10.
    exp_mem(1'b1, 16'h0010, 32'hA0);
    exp_mem(1'b1, 16'h0011, 32'hDEAD_BEEF);
    exp_mem(1'b1, 16'h0012, 32'hA2);
    exp_mem(1'b1, 16'h0013, 32'hA3);
    exp_fill(16'h0410);
    issue(1'b0, 16'h0410, '0, 3'd4, 32'hB0, 1'b1);
    issue(1'b1, 16'h0412, 32'hCAFE_0412, 3'd5, '0, 1'b0);
    idle(1);

    // Eviction back to tag 0 with five cycles of memory backpressure on the first writeback word.
    stall_armed = 1'b0;
    stall_left  = 5;
    exp_mem(1'b1, 16'h0410, 32'hB0);
    exp_mem(1'b1, 16'h0411, 32'hB1);
    exp_mem(1'b1, 16'h0412, 32'hCAFE_0412);
    exp_mem(1'b1, 16'h0413, 32'hB3);
    exp_fill(16'h0010);
    issue(1'b0, 16'h0010, '0, 3'd6, 32'hA0, 1'b1);
    check("stall_cycles_used", 32'(stall_left), 32'd0);
    issue(1'b0, 16'h0011, '0, 3'd7, 32'hDEAD_BEEF, 1'b0);
    idle(1);

    // Reset while waiting on a refill word.
    exp_mem(1'b0, 16'h0020, '0);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0020; bus.req_id = 3'd0;
    cyc = 0;
    do begin
      @(negedge clk); #2; cyc++;
    end while (!(bus.mem_req_valid && bus.mem_req_ready) && cyc < 50);
    check("fill_req_seen", 32'(bus.mem_req_valid && bus.mem_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("fill_wait_dc_miss", 32'(bus.dc_miss), 32'd1);
    check("fill_wait_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst2_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst2_mem_req_addr", 32'(bus.mem_req_addr), 32'd0);
    check("rst2_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst2_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst2_dc_miss", 32'(bus.dc_miss), 32'd0);
    @(negedge clk);
    check("post_rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    exp_fill(16'h0010);
    issue(1'b0, 16'h0010, '0, 3'd2, 32'hA0, 1'b1);
    idle(1);

    // Idle cycles with a stray refill beat; the line must be untouched.
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle_dc_miss", 32'(bus.dc_miss), 32'd0);
      check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    check("stray_consumed", 32'(stray), 32'd0);
    issue(1'b0, 16'h0010, '0, 3'd5, 32'hA0, 1'b0);
    issue(1'b0, 16'h0013, '0, 3'd6, 32'hA3, 1'b0);
    idle(3);

    check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
